// File: rtl/qspi_ctrl_pkg.sv
// Shared definitions for the QSPI controller write path: requester count,
// write-engine bus widths, the write-DMA arbiter state encoding and a
// transfer-size legality helper.
// Optional feature macro: WR_ARB_TIMEOUT_EN (adds the WAIT timeout and DRAIN state).
package qspi_ctrl_pkg;

    localparam int NUM_REQ   = 2;
    localparam int WB_ADDR_W = 32;
    localparam int WB_SIZE_W = 16;

    // The write engine only accepts word-aligned start addresses.
    localparam logic [WB_ADDR_W-1:0] WB_WORD_MASK = 32'hFFFF_FFFC;

`ifdef WR_ARB_TIMEOUT_EN
    localparam int TO_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } arb_state_t;
`endif

    // A transfer is legal only if it moves at least one whole word.
    function automatic logic size_ok(input logic [WB_SIZE_W-1:0] size);
        return (size != '0) && (size[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright; on a tie the
// requester that did not win last time is chosen. Purely combinational.
module rr_arb2
    import qspi_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] gnt
);

    // Tie-break against the previous winner; otherwise pass the request through.
    always_comb begin
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/wr_dma_arbiter.sv
// Write-DMA arbiter: picks one of two requesters, validates its transfer,
// launches the write engine and reports completion or error. Every output
// is registered.
// Optional feature macro: WR_ARB_TIMEOUT_EN (abort a WAIT that exceeds
// TIMEOUT_CYCLES, then DRAIN until the engine goes idle).
module wr_dma_arbiter
    import qspi_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [WB_ADDR_W-1:0] req_addr0,
    input  logic [WB_ADDR_W-1:0] req_addr1,
    input  logic [WB_SIZE_W-1:0] req_size0,
    input  logic [WB_SIZE_W-1:0] req_size1,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   done_o,
    output logic [NUM_REQ-1:0]   err_o,
    output logic                 wb_start,
    output logic [WB_ADDR_W-1:0] wb_addr,
    output logic [WB_SIZE_W-1:0] wb_size,
    input  logic                 wb_busy,
    input  logic                 wb_done,
    input  logic                 fifo_empty,
    output logic                 grant_id,
    output logic                 active
);

    // The timeout counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wr_dma_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    arb_state_t           state, state_nxt;
    logic                 last_grant, last_nxt;
    logic                 grant_id_nxt;
    logic [NUM_REQ-1:0]   ack_nxt, done_nxt, err_nxt;
    logic                 start_nxt;
    logic [WB_ADDR_W-1:0] addr_nxt;
    logic [WB_SIZE_W-1:0] size_nxt;

    logic [NUM_REQ-1:0]   gnt;
    logic [WB_ADDR_W-1:0] sel_addr;
    logic [WB_SIZE_W-1:0] sel_size;
    logic [NUM_REQ-1:0]   owner_onehot;

`ifdef WR_ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TO_CNT_W-1:0] to_cnt, to_cnt_nxt;
`endif

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (last_grant),
        .gnt  (gnt)
    );

    // Steer the chosen requester's descriptor and decode the current owner.
    always_comb begin
        sel_addr     = gnt[1] ? req_addr1 : req_addr0;
        sel_size     = gnt[1] ? req_size1 : req_size0;
        owner_onehot = {grant_id, ~grant_id};
    end

    // Next-state and next-output logic; pulses default to zero every cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
        state_nxt    = state;
        last_nxt     = last_grant;
        grant_id_nxt = grant_id;
        ack_nxt      = '0;
        done_nxt     = '0;
        err_nxt      = '0;
        start_nxt    = wb_start;
        addr_nxt     = wb_addr;
        size_nxt     = wb_size;
`ifdef WR_ARB_TIMEOUT_EN
        to_cnt_nxt   = to_cnt;
`endif
        unique case (state)
            ST_IDLE: begin
                start_nxt = 1'b0;
                // Waiting for wb_busy low keeps a new grant from overlapping
                // the tail of the previous transfer.
                if (!wb_busy && (req != '0)) begin
                    grant_id_nxt = gnt[1];
                    last_nxt     = gnt[1];
                    ack_nxt      = gnt;
                    if (size_ok(sel_size)) begin
                        addr_nxt  = sel_addr & WB_WORD_MASK;
                        size_nxt  = sel_size;
                        state_nxt = ST_LAUNCH;
                    end else begin
                        err_nxt = gnt;
                    end
                end
            end
            ST_LAUNCH: begin
                // Only leave once the engine has seen start, is busy and has
                // data; an empty FIFO keeps the start request standing.
                if (wb_start && wb_busy && !fifo_empty) begin
                    start_nxt = 1'b0;
                    state_nxt = ST_WAIT;
`ifdef WR_ARB_TIMEOUT_EN
                    to_cnt_nxt = '0;
`endif
                end else begin
                    start_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (wb_done) begin
                    done_nxt  = owner_onehot;
                    state_nxt = ST_IDLE;
                end
`ifdef WR_ARB_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    err_nxt    = owner_onehot;
                    to_cnt_nxt = '0;
                    state_nxt  = ST_DRAIN;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                // A late wb_done from the aborted transfer is deliberately ignored.
                if (!wb_busy) begin
                    state_nxt = ST_IDLE;
                end
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            ack        <= '0;
            done_o     <= '0;
            err_o      <= '0;
            wb_start   <= 1'b0;
            wb_addr    <= '0;
            wb_size    <= '0;
            active     <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_nxt;
            grant_id   <= grant_id_nxt;
            ack        <= ack_nxt;
            done_o     <= done_nxt;
            err_o      <= err_nxt;
            wb_start   <= start_nxt;
            wb_addr    <= addr_nxt;
            wb_size    <= size_nxt;
            active     <= (state_nxt != ST_IDLE);
        end
    end

`ifdef WR_ARB_TIMEOUT_EN
    // Cycles spent in WAIT for the current transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_wr_dma_arbiter.sv
// Directed self-checking bench for wr_dma_arbiter. Inputs change just after
// the falling edge, outputs are sampled on the falling edge.
// Optional feature macro: WR_ARB_TIMEOUT_EN (enables the timeout steps).
module tb_wr_dma_arbiter;
    import qspi_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] req_addr0, req_addr1;
    logic [15:0] req_size0, req_size1;
    logic [1:0]  ack, done_o, err_o;
    logic        wb_start;
    logic [31:0] wb_addr;
    logic [15:0] wb_size;
    logic        wb_busy, wb_done, fifo_empty;
    logic        grant_id, active;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wr_dma_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_size0  (req_size0),
        .req_size1  (req_size1),
        .ack        (ack),
        .done_o     (done_o),
        .err_o      (err_o),
        .wb_start   (wb_start),
        .wb_addr    (wb_addr),
        .wb_size    (wb_size),
        .wb_busy    (wb_busy),
        .wb_done    (wb_done),
        .fifo_empty (fifo_empty),
        .grant_id   (grant_id),
        .active     (active)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ack"},      32'(ack),      32'h0);
        check({tag, " done"},     32'(done_o),   32'h0);
        check({tag, " err"},      32'(err_o),    32'h0);
        check({tag, " wb_start"}, 32'(wb_start), 32'h0);
        check({tag, " wb_addr"},  wb_addr,       32'h0);
        check({tag, " wb_size"},  32'(wb_size),  32'h0);
        check({tag, " grant_id"}, 32'(grant_id), 32'h0);
        check({tag, " active"},   32'(active),   32'h0);
    endtask

    // Full transfer with req held by the caller; starts at the grant edge.
    task automatic do_xfer(input string tag, input logic [1:0] exp_ack,
                           input logic [31:0] exp_addr, input logic [15:0] exp_size);
        step();
        check({tag, " ack"},      32'(ack),      32'(exp_ack));
        check({tag, " grant_id"}, 32'(grant_id), 32'(exp_ack[1]));
        check({tag, " wb_addr"},  wb_addr,       exp_addr);
        check({tag, " wb_size"},  32'(wb_size),  32'(exp_size));
        step();
        check({tag, " start"},    32'(wb_start), 32'h1);
        wb_busy = 1'b1;
        step();
        check({tag, " wait start"},  32'(wb_start), 32'h0);
        check({tag, " wait active"}, 32'(active),   32'h1);
        wb_done = 1'b1;
        wb_busy = 1'b0;
        step();
        check({tag, " done"},   32'(done_o), 32'(exp_ack));
        check({tag, " idle"},   32'(active), 32'h0);
        wb_done = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req        = 2'b00;
        req_addr0  = 32'h0;
        req_addr1  = 32'h0;
        req_size0  = 16'h0;
        req_size1  = 16'h0;
        wb_busy    = 1'b0;
        wb_done    = 1'b0;
        fifo_empty = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;

        // Single requester with a misaligned address; req drops after ack.
        req       = 2'b01;
        req_addr0 = 32'h0000_1003;
        req_size0 = 16'd16;
        step();
        check("t1 ack",      32'(ack),      32'h1);
        check("t1 err",      32'(err_o),    32'h0);
        check("t1 start0",   32'(wb_start), 32'h0);
        check("t1 active",   32'(active),   32'h1);
        req = 2'b00;
        step();
        check("t1 start",    32'(wb_start), 32'h1);
        check("t1 addr",     wb_addr,       32'h0000_1000);
        check("t1 size",     32'(wb_size),  32'd16);
        check("t1 ack gone", 32'(ack),      32'h0);
        wb_busy = 1'b1;
        step();
        check("t1 wait start", 32'(wb_start), 32'h0);
        step();
        check("t1 no done",    32'(done_o),   32'h0);
        check("t1 still busy", 32'(active),   32'h1);
        wb_done = 1'b1;
        wb_busy = 1'b0;
        step();
        check("t1 done",   32'(done_o), 32'h1);
        check("t1 idle",   32'(active), 32'h0);
        wb_done = 1'b0;
        step();
        check("t1 done pulse", 32'(done_o), 32'h0);
        check("t1 no regrant", 32'(ack),    32'h0);

        // Fresh reset, then both requesters held: grants alternate 0,1,0,1.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        req_addr1 = 32'h0000_2000;
        req_size1 = 16'd64;
        req       = 2'b11;
        do_xfer("rr0", 2'b01, 32'h0000_1000, 16'd16);
        do_xfer("rr1", 2'b10, 32'h0000_2000, 16'd64);
        do_xfer("rr2", 2'b01, 32'h0000_1000, 16'd16);
        do_xfer("rr3", 2'b10, 32'h0000_2000, 16'd64);
        req = 2'b00;
        step();
        check("rr end ack", 32'(ack), 32'h0);

        // Size not a multiple of four is rejected.
        req       = 2'b10;
        req_size1 = 16'd6;
        step();
        check("bad6 ack",    32'(ack),      32'h2);
        check("bad6 err",    32'(err_o),    32'h2);
        check("bad6 active", 32'(active),   32'h0);
        req = 2'b00;
        step();
        check("bad6 start",  32'(wb_start), 32'h0);
        check("bad6 err pulse", 32'(err_o), 32'h0);
        check("bad6 idle",   32'(active),   32'h0);

        // Zero size is rejected; the rejection still moves the round-robin pointer.
        req       = 2'b01;
        req_size0 = 16'd0;
        step();
        check("bad0 ack", 32'(ack),   32'h1);
        check("bad0 err", 32'(err_o), 32'h1);
        req       = 2'b00;
        req_size0 = 16'd16;
        req_size1 = 16'd64;
        step();
        check("bad0 start", 32'(wb_start), 32'h0);
        req = 2'b11;
        do_xfer("after rej", 2'b10, 32'h0000_2000, 16'd64);
        req = 2'b00;

        // Empty FIFO keeps wb_start high for 20 cycles; done in LAUNCH is ignored.
        req        = 2'b01;
        fifo_empty = 1'b1;
        step();
        check("fifo ack", 32'(ack), 32'h1);
        req = 2'b00;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) wb_busy = 1'b1;
            wb_done = (i == 5);
            step();
            check("fifo hold start", 32'(wb_start), 32'h1);
            check("fifo no done",    32'(done_o),   32'h0);
        end
        wb_done    = 1'b0;
        fifo_empty = 1'b0;
        step();
        check("fifo wait start", 32'(wb_start), 32'h0);
        check("fifo active",     32'(active),   32'h1);
        wb_done = 1'b1;
        wb_busy = 1'b0;
        step();
        check("fifo done", 32'(done_o), 32'h1);
        wb_done = 1'b0;

        // wb_done while idle is ignored.
        wb_done = 1'b1;
        step();
        check("idle done ignored", 32'(done_o), 32'h0);
        wb_done = 1'b0;

        // Reset while in WAIT abandons the transfer silently.
        req = 2'b10;
        step();
        check("rst ack", 32'(ack), 32'h2);
        req = 2'b00;
        step();
        wb_busy = 1'b1;
        step();
        check("rst in wait", 32'(active), 32'h1);
        reset   = 1'b1;
        wb_done = 1'b1;
        step();
        check_all_zero("rst wait");
        reset   = 1'b0;
        wb_done = 1'b0;
        wb_busy = 1'b0;
        step();
        check("rst after done", 32'(done_o), 32'h0);
        check("rst after err",  32'(err_o),  32'h0);

`ifdef WR_ARB_TIMEOUT_EN
        // No wb_done: abort after 8 WAIT cycles, DRAIN until the engine idles.
        req = 2'b01;
        step();
        check("to ack", 32'(ack), 32'h1);
        req = 2'b00;
        step();
        wb_busy = 1'b1;
        step();
        check("to in wait", 32'(dut.state), 32'(ST_WAIT));
        for (int i = 1; i < 8; i++) begin
            step();
            check("to no err yet", 32'(err_o), 32'h0);
        end
        step();
        check("to err",   32'(err_o),     32'h1);
        check("to drain", 32'(dut.state), 32'(ST_DRAIN));
        wb_done = 1'b1;
        step();
        check("to late done",   32'(done_o),    32'h0);
        check("to err pulse",   32'(err_o),     32'h0);
        check("to still drain", 32'(dut.state), 32'(ST_DRAIN));
        wb_done = 1'b0;
        wb_busy = 1'b0;
        step();
        check("to idle",    32'(active), 32'h0);
        check("to no done", 32'(done_o), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wr_dma_arbiter.md
WR_DMA_ARBITER -- requirements
Module: wr_dma_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the cycle limit in WAIT before abort (used only with WR_ARB_TIMEOUT_EN).
REQ-002 SHALL have ports: clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: req  input  2  per-requester transfer request, level, held until ack.
REQ-004 SHALL have ports: req_addr0, req_addr1  input  32  byte start address per requester.
REQ-005 SHALL have ports: req_size0, req_size1  input  16  byte count per requester.
REQ-006 SHALL have ports: ack  output  2  one-cycle grant pulse; done_o  output  2  one-cycle completion pulse; err_o  output  2  one-cycle error pulse.
REQ-007 SHALL have ports: wb_start  output  1; wb_addr  output  32; wb_size  output  16; wb_busy  input  1; wb_done  input  1; fifo_empty  input  1  (write-engine side).
REQ-008 SHALL have ports: grant_id  output  1  index of current owner; active  output  1  high when state is not IDLE.

Function
REQ-009 SHALL implement states IDLE, LAUNCH, WAIT, DRAIN, all outputs registered.
REQ-010 SHALL sample req only in IDLE; when both are set, grant the requester other than last_grant (round-robin); when one is set, grant it.
REQ-011 On grant, SHALL latch the requester's addr/size into wb_addr/wb_size, pulse ack[g] for one cycle, set grant_id=g, and update last_grant, all on the same edge.
REQ-012 SHALL reject a request with size==0 or size[1:0]!=0: pulse err_o[g] and ack[g] together, stay in IDLE, update last_grant, never assert wb_start.
REQ-013 A valid grant SHALL enter LAUNCH with wb_start=1 on the next cycle; wb_addr SHALL be forced word-aligned ({addr[31:2],2'b00}).
REQ-014 In LAUNCH, SHALL hold wb_start high while fifo_empty=1 or wb_busy=0, then drop wb_start and enter WAIT on the first cycle wb_busy=1.
REQ-015 In WAIT, on wb_done=1, SHALL pulse done_o[g] for one cycle and return to IDLE; the next grant SHALL NOT be issued earlier than the cycle after wb_busy=0.
REQ-016 wb_done seen in any state other than WAIT SHALL be ignored.
REQ-017 req deassertion after ack SHALL NOT affect the running transfer.
REQ-018 ack, done_o, err_o SHALL be one-hot or zero in every cycle.

Reset
REQ-019 Reset SHALL force state=IDLE, last_grant=1 (requester 0 wins the first tie), and wb_start, ack, done_o, err_o, grant_id, active, and timeout counter to 0; wb_addr=0; wb_size=0.
REQ-020 Reset mid-transfer SHALL abandon the transfer with no done_o/err_o pulse.

Configuration
REQ-021 With WR_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles in WAIT; on reaching TIMEOUT_CYCLES, the block SHALL pulse err_o[g], enter DRAIN, and return to IDLE once wb_busy=0 (wb_done ignored in DRAIN).
REQ-022 Without WR_ARB_TIMEOUT_EN, the counter and DRAIN state SHALL be absent, and WAIT SHALL wait indefinitely for wb_done.

Structure
REQ-023 State encoding and the requester count (2) SHALL reside in shared package qspi_ctrl_pkg, alongside the write-engine constants.
REQ-024 The round-robin pick SHALL be a sub-module rr_arb2 (inputs req[1:0], last; output gnt one-hot); everything else SHALL be flat.

Verification
REQ-025 req=01, addr0=0x1003, size0=16 -> ack=01; next cycle wb_start=1, wb_addr=0x1000, wb_size=16; wb_done -> done_o=01, active=0.
REQ-026 req=11 after reset, both with valid sizes -> requester 0 is granted first; req=11 again -> requester 1 is granted; the grant order across four back-to-back transfers is 0,1,0,1.
REQ-027 req=10, size1=6 -> ack=10 and err_o=10 in the same cycle; wb_start stays 0; state stays IDLE.
REQ-028 fifo_empty=1 for 20 cycles after grant -> wb_start is held high for all 20 cycles; WAIT is entered only after wb_busy=1.
REQ-029 With WR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, and no wb_done -> err_o pulses at the 8th WAIT cycle; state is DRAIN until wb_busy=0, then IDLE; a late wb_done produces no done_o.
REQ-030 Reset asserted in WAIT -> all outputs zero on the next cycle, with no done_o or err_o pulse.
